// File: rtl/display_pkg.sv
// Shared types and default 640x480 timing for the display sync receive path.
package display_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } lock_state_e;

  localparam int unsigned DEF_CORDW       = 16;
  localparam int unsigned DEF_H_RES       = 640;
  localparam int unsigned DEF_V_RES       = 480;
  localparam int unsigned DEF_H_TOTAL     = 800;
  localparam int unsigned DEF_V_TOTAL     = 525;
  localparam int unsigned DEF_LOCK_FRAMES = 2;

endpackage

// File: rtl/display_axis_meas.sv
// Lead-to-lead period counter for one timing axis; counts 'inc' events between
// 'lead' strobes and latches the saturated period, including an inc on the lead itself.
module display_axis_meas #(
  parameter int unsigned W = 16
) (
  input  logic         clk_pix,
  input  logic         rst_pix_n,
  input  logic         inc,
  input  logic         lead,
  output logic [W-1:0] cnt,
  output logic [W-1:0] period,
  output logic [W-1:0] period_next
);

  localparam logic [W-1:0] CMAX = '1;

  logic [W-1:0] cnt_inc;

  assign cnt_inc     = (inc && cnt != CMAX) ? cnt + 1'b1 : cnt;
  assign period_next = lead ? cnt_inc : period;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      cnt    <= '0;
      period <= '0;
    end else begin
      cnt    <= lead ? '0 : cnt_inc;
      period <= period_next;
    end
  end

endmodule

// File: rtl/display_sync_decoder.sv
// Recovers active-area coordinates from hsync/vsync/de, measures line and frame
// geometry, and tracks lock against the expected video mode.
module display_sync_decoder
  import display_pkg::*;
#(
  parameter int unsigned CORDW       = DEF_CORDW,
  parameter int unsigned H_RES       = DEF_H_RES,
  parameter int unsigned V_RES       = DEF_V_RES,
  parameter int unsigned H_TOTAL     = DEF_H_TOTAL,
  parameter int unsigned V_TOTAL     = DEF_V_TOTAL,
  parameter bit          H_POL       = 1'b0,
  parameter bit          V_POL       = 1'b0,
  parameter int unsigned LOCK_FRAMES = DEF_LOCK_FRAMES
) (
  input  logic             clk_pix,
  input  logic             rst_pix_n,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             de,
  output logic             de_o,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             line,
  output logic             frame,
  output logic [CORDW-1:0] h_total_m,
  output logic [CORDW-1:0] h_active_m,
  output logic [CORDW-1:0] v_total_m,
  output logic [CORDW-1:0] v_active_m,
  output logic             locked,
  output logic             lock_lost
);

  localparam logic [CORDW-1:0] CMAX      = '1;
  localparam logic [CORDW-1:0] H_TOTAL_C = CORDW'(H_TOTAL);
  localparam logic [CORDW-1:0] H_RES_C   = CORDW'(H_RES);
  localparam logic [CORDW-1:0] V_TOTAL_C = CORDW'(V_TOTAL);
  localparam logic [CORDW-1:0] V_RES_C   = CORDW'(V_RES);
  localparam logic [CORDW-1:0] WDOG_C    = CORDW'(2 * H_TOTAL);
  localparam int unsigned      GW        = $clog2(LOCK_FRAMES + 1);
  localparam logic [GW-1:0]    LOCK_C    = GW'(LOCK_FRAMES);

  function automatic logic [CORDW-1:0] sat_inc(input logic [CORDW-1:0] v);
    return (v == CMAX) ? v : v + 1'b1;
  endfunction

  logic             hs_a, vs_a, hs_q, vs_q;
  logic             hs_lead, vs_lead, de_rise, de_fall;
  logic             frame_pend;
  logic [CORDW-1:0] v_act_cnt;
  logic [CORDW-1:0] h_cnt, v_cnt_unused;
  logic [CORDW-1:0] h_total_next, v_total_next, h_active_next;
  logic             match, wdog;
  lock_state_e      state_q, state_d;
  logic [GW-1:0]    good_q, good_d;
  logic             lost_d;

  // Edges are taken from the live input against its registered copy so that the
  // resulting coordinate registers land exactly one clock after the de sample.
  assign hs_a    = H_POL ? hsync : ~hsync;
  assign vs_a    = V_POL ? vsync : ~vsync;
  assign hs_lead = hs_a & ~hs_q;
  assign vs_lead = vs_a & ~vs_q;
  assign de_rise = de & ~de_o;
  assign de_fall = ~de & de_o;

  display_axis_meas #(.W(CORDW)) u_h_meas (
    .clk_pix     (clk_pix),
    .rst_pix_n   (rst_pix_n),
    .inc         (1'b1),
    .lead        (hs_lead),
    .cnt         (h_cnt),
    .period      (h_total_m),
    .period_next (h_total_next)
  );

  display_axis_meas #(.W(CORDW)) u_v_meas (
    .clk_pix     (clk_pix),
    .rst_pix_n   (rst_pix_n),
    .inc         (hs_lead),
    .lead        (vs_lead),
    .cnt         (v_cnt_unused),
    .period      (v_total_m),
    .period_next (v_total_next)
  );

  assign h_active_next = de_fall ? sat_inc(sx) : h_active_m;

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      de_o       <= 1'b0;
      sx         <= '0;
      sy         <= '0;
      line       <= 1'b0;
      frame      <= 1'b0;
      frame_pend <= 1'b0;
      v_act_cnt  <= '0;
      h_active_m <= '0;
      v_active_m <= '0;
    end else begin
      hs_q       <= hs_a;
      vs_q       <= vs_a;
      de_o       <= de;
      line       <= de & (de_rise | vs_lead);
      frame      <= de & (vs_lead | (frame_pend & de_rise));
      h_active_m <= h_active_next;
      // A vs lead inside active video restarts the frame on the spot.
      if (vs_lead)      frame_pend <= ~de;
      else if (de_rise) frame_pend <= 1'b0;
      if (de_rise || (de && vs_lead)) sx <= '0;
      else if (de)                    sx <= sat_inc(sx);
      if (vs_lead)      sy <= '0;
      else if (de_fall) sy <= sat_inc(sy);
      if (vs_lead)      v_act_cnt <= '0;
      else if (de_fall) v_act_cnt <= sat_inc(v_act_cnt);
      if (vs_lead)      v_active_m <= v_act_cnt;
    end
  end

  assign match = (h_total_next == H_TOTAL_C) && (h_active_next == H_RES_C) &&
                 (v_total_next == V_TOTAL_C) && (v_act_cnt == V_RES_C);
  assign wdog  = (h_cnt >= WDOG_C);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    lost_d  = 1'b0;
    unique case (state_q)
      SEARCH: begin
        if (vs_lead) begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
      end
      ACQUIRE: begin
        if (wdog) begin
          state_d = SEARCH;
        end else if (vs_lead) begin
          if (match) begin
            good_d = good_q + 1'b1;
            if (good_q + 1'b1 == LOCK_C) state_d = LOCKED;
          end else begin
            good_d = '0;
          end
        end
      end
      LOCKED: begin
        if (wdog || (vs_lead && !match)) begin
          state_d = SEARCH;
          lost_d  = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state_q   <= SEARCH;
      good_q    <= '0;
      locked    <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state_q   <= state_d;
      good_q    <= good_d;
      locked    <= (state_d == LOCKED);
      lock_lost <= lost_d;
    end
  end

endmodule

// File: tb/tb_display_sync_decoder.sv
// Bench for display_sync_decoder: reduced 32x18 mode generator, per-cycle coordinate
// scoreboard, lock/loss/watchdog/reset checks on a negative- and a positive-polarity instance.
module tb_display_sync_decoder;

  localparam int CW = 16;
  localparam int HR = 16, HT = 32, HS_STA = 20, HS_END = 28;
  localparam int VR = 12, VT = 18, VS_STA = 14, VS_END = 16;

  typedef struct {
    bit armed;
    bit de;
    int sx;
    int sy;
    bit line;
    bit frame;
  } exp_t;

  logic          clk_pix = 1'b0;
  logic          rst_pix_n, hsync, vsync, de;
  logic          hsync_p, vsync_p;
  logic          de_o [2];
  logic [CW-1:0] sx [2], sy [2];
  logic          line [2], frame [2];
  logic [CW-1:0] h_total_m [2], h_active_m [2], v_total_m [2], v_active_m [2];
  logic          locked [2], lock_lost [2];

  int   total = 0, bad = 0;
  exp_t exp_q[$];
  int   gx = 0, gy = 0, since_hs = 0, vs_leads = 0;
  bit   hs_prev = 1'b0, vs_prev = 1'b0, armed = 1'b0;
  bit   mute_en = 1'b0;
  int   mute_lo = 0, mute_hi = 0;
  int   lost_cnt [2], lost_at [2];
  logic pre_locked [2];

  assign hsync_p = ~hsync;
  assign vsync_p = ~vsync;

  always #5 clk_pix = ~clk_pix;

  display_sync_decoder #(
    .CORDW(CW), .H_RES(HR), .V_RES(VR), .H_TOTAL(HT), .V_TOTAL(VT),
    .H_POL(1'b0), .V_POL(1'b0), .LOCK_FRAMES(2)
  ) dut_n (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .hsync(hsync), .vsync(vsync), .de(de),
    .de_o(de_o[0]), .sx(sx[0]), .sy(sy[0]), .line(line[0]), .frame(frame[0]),
    .h_total_m(h_total_m[0]), .h_active_m(h_active_m[0]),
    .v_total_m(v_total_m[0]), .v_active_m(v_active_m[0]),
    .locked(locked[0]), .lock_lost(lock_lost[0])
  );

  display_sync_decoder #(
    .CORDW(CW), .H_RES(HR), .V_RES(VR), .H_TOTAL(HT), .V_TOTAL(VT),
    .H_POL(1'b1), .V_POL(1'b1), .LOCK_FRAMES(2)
  ) dut_p (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .hsync(hsync_p), .vsync(vsync_p), .de(de),
    .de_o(de_o[1]), .sx(sx[1]), .sy(sy[1]), .line(line[1]), .frame(frame[1]),
    .h_total_m(h_total_m[1]), .h_active_m(h_active_m[1]),
    .v_total_m(v_total_m[1]), .v_active_m(v_active_m[1]),
    .locked(locked[1]), .lock_lost(lock_lost[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One pixel clock: drive generator outputs, queue the expectation, then score the DUT.
  task automatic tick();
    bit   hs_act, vs_act, de_now;
    exp_t rec;
    @(negedge clk_pix);
    hs_act = (gx >= HS_STA) && (gx < HS_END) && !(mute_en && gy >= mute_lo && gy <= mute_hi);
    vs_act = (gy >= VS_STA) && (gy < VS_END);
    de_now = (gx < HR) && (gy < VR);
    hsync  = ~hs_act;
    vsync  = ~vs_act;
    de     = de_now;
    if (hs_act && !hs_prev) since_hs = 0;
    else                    since_hs++;
    if (vs_act && !vs_prev) begin
      armed = 1'b1;
      vs_leads++;
      for (int d = 0; d < 2; d++) pre_locked[d] = locked[d];
    end
    exp_q.push_back('{armed, de_now, gx, gy, de_now && gx == 0, de_now && gx == 0 && gy == 0});
    hs_prev = hs_act;
    vs_prev = vs_act;
    if (gx == HT - 1) begin
      gx = 0;
      gy = (gy == VT - 1) ? 0 : gy + 1;
    end else begin
      gx++;
    end
    @(posedge clk_pix);
    #1;
    rec = exp_q.pop_front();
    for (int d = 0; d < 2; d++) begin
      if (rec.armed) begin
        check($sformatf("de_o[%0d]", d), 32'(de_o[d]), 32'(rec.de));
        check($sformatf("line[%0d]", d), 32'(line[d]), 32'(rec.line));
        check($sformatf("frame[%0d]", d), 32'(frame[d]), 32'(rec.frame));
        if (rec.de) begin
          check($sformatf("sx[%0d]", d), 32'(sx[d]), rec.sx);
          check($sformatf("sy[%0d]", d), 32'(sy[d]), rec.sy);
        end
      end
      if (lock_lost[d]) begin
        lost_cnt[d]++;
        lost_at[d] = since_hs;
      end
    end
  endtask

  task automatic run_to_vs(input int n);
    int target;
    target = vs_leads + n;
    for (int i = 0; i < n * VT * HT + 64 && vs_leads < target; i++) tick();
  endtask

  task automatic check_zero(input string pfx);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s de_o[%0d]", pfx, d), 32'(de_o[d]), 0);
      check($sformatf("%s sx[%0d]", pfx, d), 32'(sx[d]), 0);
      check($sformatf("%s sy[%0d]", pfx, d), 32'(sy[d]), 0);
      check($sformatf("%s line[%0d]", pfx, d), 32'(line[d]), 0);
      check($sformatf("%s frame[%0d]", pfx, d), 32'(frame[d]), 0);
      check($sformatf("%s h_total_m[%0d]", pfx, d), 32'(h_total_m[d]), 0);
      check($sformatf("%s h_active_m[%0d]", pfx, d), 32'(h_active_m[d]), 0);
      check($sformatf("%s v_total_m[%0d]", pfx, d), 32'(v_total_m[d]), 0);
      check($sformatf("%s v_active_m[%0d]", pfx, d), 32'(v_active_m[d]), 0);
      check($sformatf("%s locked[%0d]", pfx, d), 32'(locked[d]), 0);
      check($sformatf("%s lock_lost[%0d]", pfx, d), 32'(lock_lost[d]), 0);
    end
  endtask

  task automatic check_locked(input string pfx, input logic exp);
    for (int d = 0; d < 2; d++)
      check($sformatf("%s locked[%0d]", pfx, d), 32'(locked[d]), 32'(exp));
  endtask

  initial begin
    rst_pix_n = 1'b1;
    hsync     = 1'b1;
    vsync     = 1'b1;
    de        = 1'b0;
    for (int d = 0; d < 2; d++) begin
      lost_cnt[d]   = 0;
      lost_at[d]    = -1;
      pre_locked[d] = 1'b0;
    end
    #1 rst_pix_n = 1'b0;
    #2 check_zero("reset");
    repeat (3) @(posedge clk_pix);
    #1 rst_pix_n = 1'b1;

    // Clean frames: first vs lead is discarded, lock after two matching frames.
    run_to_vs(1);
    check_locked("vs1", 1'b0);
    run_to_vs(1);
    check_locked("vs2", 1'b0);
    run_to_vs(1);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("vs3 pre_locked[%0d]", d), 32'(pre_locked[d]), 0);
      check($sformatf("h_total_m[%0d]", d), 32'(h_total_m[d]), HT);
      check($sformatf("h_active_m[%0d]", d), 32'(h_active_m[d]), HR);
      check($sformatf("v_total_m[%0d]", d), 32'(v_total_m[d]), VT);
      check($sformatf("v_active_m[%0d]", d), 32'(v_active_m[d]), VR);
      check($sformatf("no_loss_yet[%0d]", d), 32'(lost_cnt[d]), 0);
    end
    check_locked("vs3", 1'b1);

    // One missing hsync pulse: frame check fails at the next vs lead.
    mute_en = 1'b1; mute_lo = 3; mute_hi = 3;
    run_to_vs(1);
    mute_en = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("drop pre_locked[%0d]", d), 32'(pre_locked[d]), 1);
      check($sformatf("drop lost_cnt[%0d]", d), 32'(lost_cnt[d]), 1);
      check($sformatf("drop v_total_m[%0d]", d), 32'(v_total_m[d]), VT - 1);
      check($sformatf("drop h_total_m[%0d]", d), 32'(h_total_m[d]), HT);
    end
    check_locked("drop", 1'b0);
    run_to_vs(3);
    check_locked("relock1", 1'b1);

    // hsync held inactive for three lines: watchdog fires once h_cnt reaches 64.
    for (int d = 0; d < 2; d++) lost_cnt[d] = 0;
    mute_en = 1'b1; mute_lo = 4; mute_hi = 6;
    run_to_vs(1);
    mute_en = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("wdog lost_cnt[%0d]", d), 32'(lost_cnt[d]), 1);
      check($sformatf("wdog lost_at[%0d]", d), 32'(lost_at[d]), 2 * HT + 1);
    end
    check_locked("wdog", 1'b0);
    run_to_vs(2);
    check_locked("relock2", 1'b1);

    // Reset in the middle of an active line, generator keeps running.
    for (int i = 0; i < 2 * VT * HT && !(gy == 5 && gx == 9); i++) tick();
    rst_pix_n = 1'b0;
    armed     = 1'b0;
    #1 check_zero("midreset");
    repeat (3) tick();
    rst_pix_n = 1'b1;
    run_to_vs(1);
    check_locked("partial", 1'b0);
    run_to_vs(1);
    check_locked("full1", 1'b0);
    run_to_vs(1);
    for (int d = 0; d < 2; d++)
      check($sformatf("full2 pre_locked[%0d]", d), 32'(pre_locked[d]), 0);
    check_locked("full2", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
